// File: rtl/stage3_pc_hart_sched.sv
// Multi-hart PC unit for stage3 fetch: per-hart PC registers, round-robin hart selection,
// a valid/ready request to fetch, and redirects from execute.
module stage3_pc_hart_sched #(
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] RESET_PC  = 32'h80000000,
    localparam int         HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_HARTS-1:0]        hart_enable,
    output logic                        fetch_valid,
    input  logic                        fetch_ready,
    output logic [31:0]                 fetch_pc,
    output logic [HART_W-1:0]           fetch_hart_id,
    input  logic [31:0]                 npc,
    input  logic                        redirect_valid,
    input  logic [HART_W-1:0]           redirect_hart,
    input  logic [31:0]                 redirect_pc,
    output logic [NUM_HARTS-1:0][31:0]  pc,
    output logic                        dbg_locked
);

    // Handshake: fetch_valid/fetch_pc/fetch_hart_id form a request; it completes (fire) in a
    // cycle where fetch_valid & fetch_ready. Once presented and stalled, hart id stays fixed
    // until fire; only a redirect of that same hart may change fetch_pc meanwhile.
    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

    localparam logic [HART_W:0]   NH   = (HART_W+1)'(NUM_HARTS);
    localparam logic [HART_W-1:0] LAST = HART_W'(NUM_HARTS - 1);

    state_t              state, state_nxt;
    logic [HART_W-1:0]   rr_ptr;
    logic [HART_W-1:0]   sel;
    logic [HART_W-1:0]   grant;
    logic                any_en;
    logic                fire;
    logic                redir_hit;

    assign any_en    = |hart_enable;
    assign fire      = fetch_valid & fetch_ready;
    assign redir_hit = redirect_valid && ({1'b0, redirect_hart} < NH);
    assign dbg_locked = (state == ST_LOCK);

    // Round-robin scan starting at rr_ptr, wrapping at NUM_HARTS.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_HARTS) j = j - NUM_HARTS;
            if (!found && hart_enable[j]) begin
                grant = HART_W'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_ARB;
            rr_ptr <= '0;
            sel    <= '0;
            for (int h = 0; h < NUM_HARTS; h++) pc[h] <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (state == ST_ARB) sel <= grant;
            if (fire) rr_ptr <= (fetch_hart_id == LAST) ? '0 : fetch_hart_id + HART_W'(1);
            // Redirect has priority over the returned npc for the same hart.
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (redir_hit && redirect_hart == HART_W'(h))
                    pc[h] <= {redirect_pc[31:2], 2'b00};
                else if (fire && fetch_hart_id == HART_W'(h))
                    pc[h] <= {npc[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:  if (fetch_valid && !fetch_ready) state_nxt = ST_LOCK;
            ST_LOCK: if (fetch_ready) state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
        endcase
    end

    always_comb begin
        fetch_valid   = 1'b0;
        fetch_hart_id = grant;
        if (state == ST_LOCK) begin
            fetch_valid   = !RST;
            fetch_hart_id = sel;
        end else begin
            fetch_valid   = !RST && any_en;
        end
        fetch_pc = pc[0];
        for (int h = 0; h < NUM_HARTS; h++)
            if (fetch_hart_id == HART_W'(h)) fetch_pc = pc[h];
    end

endmodule
